// File: rtl/rv64im_fetch_unit.sv
// rtl/rv64im_fetch_unit.sv - RV64IM fetch stage: PC, one-outstanding imem requests, 2-entry instruction FIFO
module rv64im_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [63:0] inst_pc,
    output logic        fetch_error
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HALT} state_t;

    localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] req_pc_q, req_pc_d;
    logic        err_q, err_d;
    logic [1:0]  count_q, count_d;
    logic [95:0] ent_q [2];
    logic [95:0] ent_d [2];

    logic        req_fire;
    logic        push;
    logic        pop;
    logic        flush;
    logic        resp_pending;
    logic [1:0]  wr_idx;

    assign imem_req_valid = !rst && (state_q == S_REQ) && (count_q < DEPTH);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign inst_valid     = (count_q != 2'd0);
    assign inst_data      = ent_q[0][31:0];
    assign inst_pc        = ent_q[0][95:32];
    assign fetch_error    = err_q;
    assign pop            = inst_valid && inst_ready && !flush;
    // A request still owes a response after this cycle: it must be drained, not pushed.
    assign resp_pending   = ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_resp_valid) || req_fire;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        err_d    = err_q;
        push     = 1'b0;
        flush    = 1'b0;
        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 64'd4;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    push    = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_HALT;
        endcase
        if (redirect_valid && state_q != S_HALT) begin
            flush = 1'b1;
            push  = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                err_d   = 1'b1;
                state_d = S_HALT;
            end else begin
                pc_d    = redirect_pc;
                state_d = resp_pending ? S_DRAIN : S_REQ;
            end
        end
    end

    // Head always lives in entry 0 so the execute-facing outputs come straight from flops.
    always_comb begin
        ent_d[0] = ent_q[0];
        ent_d[1] = ent_q[1];
        count_d  = count_q;
        wr_idx   = count_q - {1'b0, pop};
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                ent_d[0] = ent_q[1];
            end
            if (push) begin
                ent_d[wr_idx[0]] = {req_pc_q, imem_resp_data};
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= 64'd0;
            err_q    <= 1'b0;
            count_q  <= 2'd0;
            ent_q[0] <= 96'd0;
            ent_q[1] <= 96'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            err_q    <= err_d;
            count_q  <= count_d;
            ent_q[0] <= ent_d[0];
            ent_q[1] <= ent_d[1];
        end
    end

endmodule

// File: tb/tb_rv64im_fetch_unit.sv
// tb/tb_rv64im_fetch_unit.sv - scoreboard bench for rv64im_fetch_unit with random memory/execute model
module tb_rv64im_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        fetch_error;

    rv64im_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .fetch_error     (fetch_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_consumed = 0;
    int          hs_total = 0;

    logic [63:0] model_pc;
    bit          halted;
    bit          mem_pending;
    logic [63:0] mem_addr;
    int          mem_cnt;
    bit          hs_now;
    logic [63:0] hs_addr;
    logic [63:0] last_hs_addr;
    bit          saw_wrap;
    logic [63:0] watch_pc;
    bit          saw_watch;

    int          p_req_ready;
    int          p_inst_ready;
    int          p_redir;
    int          min_lat;
    int          max_lat;
    bit          force_redir;
    bit          redir_wait_only;
    logic [63:0] force_pc;
    bit          force_pop;

    function automatic logic [31:0] hashf(logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_true(string name, bit cond);
        n_cmp++;
        if (!cond) begin
            n_err++;
            $display("FAIL %s: condition false at %0t", name, $time);
        end
    endtask

    // One clock: sample and update the model at negedge, then play memory/execute after posedge.
    task automatic step();
        @(negedge clk);
        if (rst) begin
            chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
            chk("rst_inst_valid", 64'(inst_valid), 64'd0);
            chk("rst_inst_data", 64'(inst_data), 64'd0);
            chk("rst_inst_pc", inst_pc, 64'd0);
            chk("rst_fetch_error", 64'(fetch_error), 64'd0);
            sb.delete();
            model_pc    = RESET_PC;
            mem_pending = 1'b0;
            halted      = 1'b0;
            hs_now      = 1'b0;
        end else begin
            if (halted) begin
                chk("halt_req_valid", 64'(imem_req_valid), 64'd0);
                chk("halt_inst_valid", 64'(inst_valid), 64'd0);
                chk("halt_fetch_error", 64'(fetch_error), 64'd1);
            end else begin
                chk("fetch_error_clear", 64'(fetch_error), 64'd0);
                if (sb.size() >= 2)
                    chk("backpressure_req_valid", 64'(imem_req_valid), 64'd0);
            end
            hs_now  = imem_req_valid && imem_req_ready;
            hs_addr = imem_req_addr;
            if (hs_now) begin
                chk("req_addr", imem_req_addr, model_pc);
                chk_true("single_outstanding", !mem_pending);
                if (imem_req_addr == 64'd0 && last_hs_addr == 64'hFFFF_FFFF_FFFF_FFFC)
                    saw_wrap = 1'b1;
                last_hs_addr = imem_req_addr;
                sb.push_back('{pc: model_pc, data: hashf(model_pc)});
                model_pc = model_pc + 64'd4;
                hs_total++;
            end
            if (redirect_valid) begin
                sb.delete();
                if (redirect_pc[1:0] != 2'b00) halted = 1'b1;
                else model_pc = redirect_pc;
            end
        end
        @(posedge clk);
        #1;
        if (imem_resp_valid) mem_pending = 1'b0;
        if (hs_now) begin
            mem_pending = 1'b1;
            mem_addr    = hs_addr;
            mem_cnt     = $urandom_range(max_lat - 1, min_lat - 1);
        end
        if (rst) begin
            imem_req_ready  = 1'b0;
            inst_ready      = 1'b0;
            redirect_valid  = 1'b0;
            redirect_pc     = 64'd0;
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'd0;
        end else begin
            imem_req_ready = ($urandom_range(99, 0) < p_req_ready);
            inst_ready     = ($urandom_range(99, 0) < p_inst_ready) || force_pop;
            force_pop      = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = {$urandom, $urandom};
            if (force_redir && (!redir_wait_only || hs_now)) begin
                redirect_valid = 1'b1;
                redirect_pc    = force_pc;
                force_redir    = 1'b0;
            end else if (!halted && !force_redir && $urandom_range(99, 0) < p_redir) begin
                redirect_valid = 1'b1;
                redirect_pc    = RESET_PC + {52'd0, 10'($urandom_range(255, 0)), 2'b00};
            end
            if (redirect_valid) inst_ready = 1'b0;
            if (mem_pending && mem_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = hashf(mem_addr);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
                if (mem_pending) mem_cnt--;
            end
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        if (!rst && inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
                chk_true("pop_with_empty_scoreboard", 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("inst_pc", inst_pc, e.pc);
                chk("inst_data", 64'(inst_data), 64'(e.data));
                n_consumed++;
                if (inst_pc == watch_pc) saw_watch = 1'b1;
            end
        end
    end

    initial begin
        int c0;
        int h0;
        rst = 1'b1;
        imem_req_ready = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
        imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
        model_pc = RESET_PC; halted = 1'b0; mem_pending = 1'b0; mem_cnt = 0;
        hs_now = 1'b0; hs_addr = 64'd0; last_hs_addr = 64'd0; saw_wrap = 1'b0;
        watch_pc = 64'h1; saw_watch = 1'b0; force_redir = 1'b0; redir_wait_only = 1'b0;
        force_pc = 64'd0; force_pop = 1'b0;
        p_req_ready = 100; p_inst_ready = 100; p_redir = 0; min_lat = 1; max_lat = 1;

        repeat (3) step();
        rst = 1'b0;

        c0 = n_consumed;
        repeat (30) step();
        chk_true("stream_throughput", (n_consumed - c0) >= 12);

        p_inst_ready = 0;
        repeat (20) step();
        chk("bp_full_depth", 64'(sb.size()), 64'd2);
        chk("bp_inst_valid", 64'(inst_valid), 64'd1);
        h0 = hs_total;
        force_pop = 1'b1;
        repeat (12) step();
        chk("bp_one_pop_one_request", 64'(hs_total - h0), 64'd1);

        p_inst_ready = 100; min_lat = 3; max_lat = 3;
        watch_pc = 64'h0000_0000_8000_1000; saw_watch = 1'b0;
        force_pc = 64'h0000_0000_8000_1000; redir_wait_only = 1'b1; force_redir = 1'b1;
        repeat (30) step();
        chk_true("redirect_in_wait_issued", !force_redir);
        chk_true("redirect_target_fetched", saw_watch);

        p_req_ready = 60; p_inst_ready = 70; p_redir = 4; min_lat = 1; max_lat = 3;
        redir_wait_only = 1'b0;
        c0 = n_consumed;
        repeat (400) step();
        chk_true("random_progress", (n_consumed - c0) >= 30);

        p_req_ready = 100; p_inst_ready = 100; p_redir = 0; min_lat = 1; max_lat = 1;
        saw_wrap = 1'b0; watch_pc = 64'hFFFF_FFFF_FFFF_FFFC; saw_watch = 1'b0;
        force_pc = 64'hFFFF_FFFF_FFFF_FFFC; force_redir = 1'b1;
        repeat (20) step();
        chk_true("wrap_requests", saw_wrap);
        chk_true("wrap_inst_fetched", saw_watch);

        force_pc = 64'h0000_0000_8000_0002; force_redir = 1'b1;
        repeat (20) step();
        chk("misaligned_fetch_error", 64'(fetch_error), 64'd1);

        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        c0 = n_consumed;
        repeat (20) step();
        chk_true("restart_after_reset", (n_consumed - c0) >= 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
